// File: rtl/arbitro_pkg.sv
// Shared types and default sizing for the round-robin compute arbiter.
package arbitro_pkg;
  localparam int N_DEF       = 4;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    LIMPA   = 2'd2
  } estado_t;
endpackage

// File: rtl/seletor_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module seletor_rr #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);
  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found        = 1'b1;
        win[pos]     = 1'b1;
        win_idx      = pos;
      end
    end
  end
endmodule

// File: rtl/arbitro_calculo.sv
// Round-robin arbiter sharing one compute unit among N requesters.
// Define ARBITRO_TIMEOUT_EN to add the CALCULA watchdog (erro pulse + forced unit reset).
module arbitro_calculo
  import arbitro_pkg::*;
#(
  parameter int N              = N_DEF,
  parameter int DW             = DW_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] x_in,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   y_out,
  output logic            erro,
  output logic            inicio,
  output logic [DW-1:0]   x_unid,
  output logic            rst_unid,
  input  logic            pronto,
  input  logic [DW-1:0]   y_unid
);
  localparam int IW = $clog2(N);

  estado_t       estado, estado_d;
  logic [IW-1:0] ptr, ptr_d, idx, idx_d;
  logic [N-1:0]  gnt_d, ack_d;
  logic [DW-1:0] y_d, xu_d;
  logic          inicio_d, ru_d;
  logic [N-1:0]  sel_win;
  logic [IW-1:0] sel_idx;

  seletor_rr #(.N(N), .IW(IW)) u_sel (
    .req     (req),
    .ptr     (ptr),
    .win     (sel_win),
    .win_idx (sel_idx)
  );

`ifdef ARBITRO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  logic [CW-1:0] cnt, cnt_d;
  logic          erro_d;
  logic          estouro;
  assign estouro = (cnt == CW'(TIMEOUT_CICLOS));
`else
  assign erro = 1'b0;
`endif

  always_comb begin
    estado_d = estado;
    ptr_d    = ptr;
    idx_d    = idx;
    gnt_d    = gnt;
    ack_d    = '0;
    y_d      = y_out;
    inicio_d = inicio;
    xu_d     = x_unid;
    ru_d     = rst_unid;
`ifdef ARBITRO_TIMEOUT_EN
    cnt_d    = cnt;
    erro_d   = 1'b0;
`endif
    case (estado)
      OCIOSO: begin
        ru_d     = 1'b0;
        gnt_d    = '0;
        inicio_d = 1'b0;
        if (|req) begin
          idx_d    = sel_idx;
          gnt_d    = sel_win;
          xu_d     = x_in[int'(sel_idx)*DW +: DW];
          inicio_d = 1'b1;
          estado_d = CALCULA;
`ifdef ARBITRO_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      CALCULA: begin
        // pronto is checked before the watchdog so a same-cycle finish still acks
        if (pronto) begin
          y_d        = y_unid;
          ack_d[idx] = 1'b1;
          inicio_d   = 1'b0;
          ru_d       = 1'b1;
          estado_d   = LIMPA;
        end
`ifdef ARBITRO_TIMEOUT_EN
        else if (estouro) begin
          erro_d   = 1'b1;
          inicio_d = 1'b0;
          ru_d     = 1'b1;
          estado_d = LIMPA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
`endif
      end
      LIMPA: begin
        ru_d     = 1'b0;
        gnt_d    = '0;
        ptr_d    = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado   <= OCIOSO;
      ptr      <= '0;
      idx      <= '0;
      gnt      <= '0;
      ack      <= '0;
      y_out    <= '0;
      inicio   <= 1'b0;
      x_unid   <= '0;
      rst_unid <= 1'b1;
    end else begin
      estado   <= estado_d;
      ptr      <= ptr_d;
      idx      <= idx_d;
      gnt      <= gnt_d;
      ack      <= ack_d;
      y_out    <= y_d;
      inicio   <= inicio_d;
      x_unid   <= xu_d;
      rst_unid <= ru_d;
    end
  end

`ifdef ARBITRO_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      erro <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      erro <= erro_d;
    end
  end
`endif
endmodule

// File: tb/tb_arbitro_calculo.sv
// Self-checking bench for arbitro_calculo: random requests against a round-robin reference model.
module tb_arbitro_calculo;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] x_in = '0;
  logic [N-1:0]  gnt, ack;
  logic [DW-1:0] y_out, x_unid;
  logic [DW-1:0] y_unid = '0;
  logic          erro, inicio, rst_unid;
  logic          pronto = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int mptr = 0;
  bit unit_dead = 0;
  bit force_p = 0;
  int ucnt = 0;

  typedef struct {
    logic [N-1:0]  g;
    logic [DW-1:0] xu;
    logic [N-1:0]  a;
    logic [DW-1:0] y;
    logic          e;
    int            lat;
    logic          ru_end;
    logic [N-1:0]  g_gap;
    logic          ru_gap;
  } obs_t;

  arbitro_calculo #(.N(N), .DW(DW), .TIMEOUT_CICLOS(15)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt), .ack(ack),
    .y_out(y_out), .erro(erro), .inicio(inicio), .x_unid(x_unid),
    .rst_unid(rst_unid), .pronto(pronto), .y_unid(y_unid)
  );

  always #5 clk = ~clk;

  // Compute unit: result x+1 ready 8 cycles after inicio is seen, held until reset.
  always @(negedge clk) begin
    if (force_p) begin
      pronto = 1'b1;
      y_unid = 8'hEE;
    end else if (rst_unid || !inicio) begin
      pronto = 1'b0;
      ucnt = 0;
    end else if (!pronto && !unit_dead) begin
      ucnt++;
      if (ucnt == 8) begin
        pronto = 1'b1;
        y_unid = x_unid + 8'd1;
      end
    end
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [DW-1:0] opnd(input logic [N*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  // Runs one transaction and records what the DUT did; callers judge the result.
  task automatic serve(input logic [N-1:0] r, input bit drop, input bit scramble, output obs_t o);
    bit seen;
    o.g = '0; o.xu = '0; o.a = '0; o.y = '0; o.e = 1'b0; o.lat = -1;
    o.ru_end = 1'b0; o.g_gap = '1; o.ru_gap = 1'b1;
    req = r;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1;
    end
    if (!seen) return;
    o.g = gnt;
    o.xu = x_unid;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 2 && drop) req = req & ~o.g;
      if (k == 2 && scramble) x_in = $urandom();
      if (ack != '0 || erro) begin
        seen = 1;
        o.a = ack; o.y = y_out; o.e = erro; o.lat = k; o.ru_end = rst_unid;
      end
    end
    if (!seen) return;
    @(negedge clk);
    o.g_gap = gnt;
    o.ru_gap = rst_unid;
  endtask

  task automatic test_reset();
    logic [2*N+2*DW+2:0] got, want;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    got  = {gnt, ack, y_out, erro, inicio, x_unid, rst_unid};
    want = {{(2*N+2*DW+2){1'b0}}, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_outputs: got %h want %h", got, want); end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rst_unid !== 1'b0) begin miscompares++; $display("FAIL reset_release_rst_unid: got %b want 0", rst_unid); end
    mptr = 0;
  endtask

  task automatic test_all_req();
    obs_t o;
    int w;
    int order [5] = '{0, 1, 2, 3, 0};
    x_in = $urandom();
    for (int t = 0; t < 5; t++) begin
      w = rr_pick(4'hF, mptr);
      serve(4'hF, 0, 0, o);
      vectors++;
      if (w != order[t]) begin miscompares++; $display("FAIL all_order_model: got %0d want %0d", w, order[t]); end
      vectors++;
      if (o.g !== 4'(1 << w)) begin miscompares++; $display("FAIL all_gnt[%0d]: got %b want %b", t, o.g, 4'(1 << w)); end
      vectors++;
      if (o.a !== 4'(1 << w) || o.y !== opnd(x_in, w) + 8'd1) begin
        miscompares++; $display("FAIL all_ack[%0d]: got %b/%h want %b/%h", t, o.a, o.y, 4'(1 << w), opnd(x_in, w) + 8'd1);
      end
      vectors++;
      if (o.g_gap !== '0) begin miscompares++; $display("FAIL all_gap[%0d]: got %b want 0000", t, o.g_gap); end
      mptr = (w + 1) % N;
    end
    req = '0;
  endtask

  task automatic test_single();
    obs_t o;
    x_in = $urandom();
    x_in[2*DW +: DW] = 8'h2A;
    serve(4'b0100, 0, 0, o);
    vectors++;
    if (o.g !== 4'b0100 || o.xu !== 8'h2A) begin miscompares++; $display("FAIL single_grant: got %b/%h want 0100/2a", o.g, o.xu); end
    vectors++;
    if (o.a !== 4'b0100 || o.y !== 8'h2B) begin miscompares++; $display("FAIL single_ack: got %b/%h want 0100/2b", o.a, o.y); end
    vectors++;
    if (o.lat != 8 || o.ru_end !== 1'b1 || o.ru_gap !== 1'b0) begin
      miscompares++; $display("FAIL single_timing: got lat %0d ru %b/%b want 8 1/0", o.lat, o.ru_end, o.ru_gap);
    end
    mptr = 3;
    req = '0;
  endtask

  task automatic test_withdraw();
    obs_t o;
    logic [DW-1:0] x1;
    x_in = $urandom();
    x1 = opnd(x_in, 1);
    serve(4'b0010, 1, 1, o);
    vectors++;
    if (o.g !== 4'b0010 || o.xu !== x1) begin miscompares++; $display("FAIL withdraw_grant: got %b/%h want 0010/%h", o.g, o.xu, x1); end
    vectors++;
    if (o.a !== 4'b0010 || o.y !== x1 + 8'd1) begin miscompares++; $display("FAIL withdraw_ack: got %b/%h want 0010/%h", o.a, o.y, x1 + 8'd1); end
    mptr = 2;
    req = '0;
  endtask

  task automatic test_idle_hold();
    logic [DW-1:0] yh;
    int bad_ack;
    yh = y_out;
    bad_ack = 0;
    force_p = 1;
    repeat (4) begin
      @(negedge clk);
      if (ack != '0 || gnt != '0) bad_ack++;
    end
    force_p = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bad_ack != 0) begin miscompares++; $display("FAIL idle_pronto_ignored: got %0d events want 0", bad_ack); end
    vectors++;
    if (y_out !== yh) begin miscompares++; $display("FAIL idle_y_hold: got %h want %h", y_out, yh); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [N-1:0] r;
    logic [N*DW-1:0] xs;
    logic [DW-1:0] yh;
    int w;
    for (int t = 0; t < 14; t++) begin
      r = 4'($urandom_range(1, 15));
      x_in = $urandom();
      xs = x_in;
      w = rr_pick(r, mptr);
      serve(r, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), o);
      vectors++;
      if (o.g !== 4'(1 << w) || o.xu !== opnd(xs, w)) begin
        miscompares++; $display("FAIL rand_grant[%0d] req %b: got %b/%h want %b/%h", t, r, o.g, o.xu, 4'(1 << w), opnd(xs, w));
      end
      vectors++;
      if (o.a !== 4'(1 << w) || o.y !== opnd(xs, w) + 8'd1 || o.e !== 1'b0) begin
        miscompares++; $display("FAIL rand_ack[%0d]: got %b/%h/%b want %b/%h/0", t, o.a, o.y, o.e, 4'(1 << w), opnd(xs, w) + 8'd1);
      end
      mptr = (w + 1) % N;
      if ($urandom_range(0, 2) == 0) begin
        req = '0;
        yh = y_out;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        vectors++;
        if (y_out !== yh) begin miscompares++; $display("FAIL rand_y_hold[%0d]: got %h want %h", t, y_out, yh); end
      end
    end
    req = '0;
    @(negedge clk);
  endtask

`ifdef ARBITRO_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    int w;
    unit_dead = 1;
    x_in = $urandom();
    w = rr_pick(4'b1111, mptr);
    serve(4'b1111, 0, 0, o);
    unit_dead = 0;
    vectors++;
    if (o.g !== 4'(1 << w)) begin miscompares++; $display("FAIL timeout_grant: got %b want %b", o.g, 4'(1 << w)); end
    vectors++;
    if (o.e !== 1'b1 || o.a !== '0 || o.lat != 16) begin
      miscompares++; $display("FAIL timeout_erro: got erro %b ack %b lat %0d want 1 0000 16", o.e, o.a, o.lat);
    end
    vectors++;
    if (o.ru_end !== 1'b1 || o.ru_gap !== 1'b0 || o.g_gap !== '0) begin
      miscompares++; $display("FAIL timeout_cleanup: got ru %b/%b gap %b want 1/0 0000", o.ru_end, o.ru_gap, o.g_gap);
    end
    vectors++;
    if (erro !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse_width: got %b want 0", erro); end
    mptr = (w + 1) % N;
    w = rr_pick(4'b1111, mptr);
    serve(4'b1111, 0, 0, o);
    vectors++;
    if (o.g !== 4'(1 << w) || o.a !== 4'(1 << w)) begin
      miscompares++; $display("FAIL timeout_next: got %b/%b want %b", o.g, o.a, 4'(1 << w));
    end
    mptr = (w + 1) % N;
    req = '0;
  endtask
`else
  task automatic test_timeout();
    int w, errs, acks, lost;
    bit seen;
    unit_dead = 1;
    x_in = $urandom();
    w = rr_pick(4'b0110, mptr);
    req = 4'b0110;
    errs = 0; acks = 0; lost = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (erro) errs++;
      if (ack != '0) acks++;
      if (gnt !== 4'(1 << w) || inicio !== 1'b1) lost++;
    end
    vectors++;
    if (errs != 0 || acks != 0) begin miscompares++; $display("FAIL wait_no_erro: got erro %0d ack %0d want 0 0", errs, acks); end
    vectors++;
    if (lost != 0) begin miscompares++; $display("FAIL wait_held: got %0d lost cycles want 0", lost); end
    unit_dead = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ack != '0) seen = 1;
    end
    vectors++;
    if (ack !== 4'(1 << w) || y_out !== opnd(x_in, w) + 8'd1) begin
      miscompares++; $display("FAIL wait_resume: got %b/%h want %b/%h", ack, y_out, 4'(1 << w), opnd(x_in, w) + 8'd1);
    end
    mptr = (w + 1) % N;
    req = '0;
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    obs_t o;
    logic [2*N+2*DW+2:0] got, want;
    int acks;
    bit seen;
    x_in = $urandom();
    req = 4'b1000;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (gnt != '0) seen = 1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    got  = {gnt, ack, y_out, erro, inicio, x_unid, rst_unid};
    want = {{(2*N+2*DW+2){1'b0}}, 1'b1};
    vectors++;
    if (got !== want) begin miscompares++; $display("FAIL midreset_outputs: got %h want %h", got, want); end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack != '0 || rst_unid !== 1'b1) acks++;
    end
    vectors++;
    if (acks != 0) begin miscompares++; $display("FAIL midreset_hold: got %0d bad cycles want 0", acks); end
    rst = 1'b1;
    mptr = 0;
    serve(4'b0001, 0, 0, o);
    vectors++;
    if (o.g !== 4'b0001 || o.a !== 4'b0001 || o.y !== opnd(x_in, 0) + 8'd1) begin
      miscompares++; $display("FAIL midreset_regrant: got %b/%b/%h want 0001/0001/%h", o.g, o.a, o.y, opnd(x_in, 0) + 8'd1);
    end
    req = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_req();
    test_single();
    test_withdraw();
    test_idle_hold();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arbitro_calculo.md
ARBITRO_CALCULO -- requirements
Module: arbitro_calculo

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 8: operand/result width.
REQ-003 SHALL have parameter TIMEOUT_CICLOS, default 15: watchdog limit in cycles, at least 10.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N  request per requester.
- x_in  in  N*DW  operand; requester i uses bits [i*DW +: DW].
- gnt  out  N  one-hot grant, held for the whole transaction.
- ack  out  N  one-cycle pulse, result valid on y_out.
- y_out  out  DW  result of the last completed transaction.
- erro  out  1  one-cycle timeout pulse.
- inicio  out  1  start to the compute unit.
- x_unid  out  DW  operand to the compute unit.
- rst_unid  out  1  active-high reset to the compute unit.
- pronto  in  1  compute unit done; held high until the unit is reset.
- y_unid  in  DW  compute unit result, valid while pronto=1.

Function
REQ-006 SHALL implement the FSM states OCIOSO, CALCULA and LIMPA; all outputs SHALL be registered.
REQ-007 In OCIOSO with req!=0, the block SHALL pick a winner by round-robin, starting its search at pointer ptr and increasing the index modulo N.
- On the same edge it SHALL latch idx, x_unid=x_in[idx], gnt=1<<idx and inicio=1.
- It SHALL then go to CALCULA.
REQ-008 In OCIOSO with req==0, the block SHALL hold gnt=0 and inicio=0.
REQ-009 In CALCULA, inicio SHALL stay 1 until pronto is sampled high.
REQ-010 On the first cycle pronto is sampled high in CALCULA, on the next edge the block SHALL:
- set y_out=y_unid and ack[idx]=1 for exactly one cycle;
- set inicio=0 and rst_unid=1;
- go to LIMPA.
REQ-011 LIMPA SHALL last exactly one cycle. On the next edge the block SHALL:
- set rst_unid=0 and gnt=0;
- set ptr=(idx+1) mod N;
- go to OCIOSO.
REQ-012 There SHALL be at least one OCIOSO cycle between transactions, with gnt=0 in that cycle.
REQ-013 Requester i dropping req[i] after being granted SHALL NOT abort the transaction; ack[i] SHALL still pulse.
REQ-014 Changes on x_in after the grant edge SHALL NOT affect x_unid.
REQ-015 A requester holding req after its ack SHALL get the lowest priority in the next arbitration.
REQ-016 Simultaneous requests SHALL be served in round-robin order; with ptr=0 this is 0,1,2,3,0...
REQ-017 pronto seen outside CALCULA SHALL be ignored.
REQ-018 y_out SHALL hold its value between transactions.

Reset
REQ-019 While rst=0 the outputs SHALL be:
- gnt=0, ack=0, y_out=0, erro=0, inicio=0, x_unid=0;
- rst_unid=1 (the unit is held in reset);
- state=OCIOSO, ptr=0, idx=0.
REQ-020 rst_unid SHALL fall on the first rising edge after rst goes high.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction with no ack.

Configuration
REQ-022 Macro ARBITRO_TIMEOUT_EN SHALL control the watchdog.
REQ-023 With ARBITRO_TIMEOUT_EN defined:
- a counter of $clog2(TIMEOUT_CICLOS+1) bits SHALL clear on entry to CALCULA and increment each CALCULA cycle;
- when it reaches TIMEOUT_CICLOS without pronto, the next edge SHALL set erro=1 for one cycle, rst_unid=1 and inicio=0, with no ack, and go to LIMPA;
- ptr SHALL then advance as in REQ-011.
REQ-024 If pronto and the timeout occur in the same cycle, pronto SHALL win.
REQ-025 Without ARBITRO_TIMEOUT_EN:
- CALCULA SHALL wait indefinitely;
- erro SHALL be constant 0;
- no counter logic SHALL be synthesized.

Structure
REQ-026 A shared package arbitro_pkg SHALL hold the FSM state typedef (OCIOSO=2'd0, CALCULA=2'd1, LIMPA=2'd2) and the default values of N, DW and TIMEOUT_CICLOS.
REQ-027 The block SHALL contain one combinational sub-module, seletor_rr (inputs req and ptr, outputs a one-hot winner and its index), instantiated once.

Verification
REQ-028 The bench SHALL model the unit as pronto rising 8 cycles after inicio is sampled, with y_unid=x+1, held until rst_unid.
REQ-029 Single request: req=4'b0100, x_in[2]=8'h2A -> gnt=4'b0100 one cycle later, x_unid=8'h2A, then ack=4'b0100 with y_out=8'h2B one cycle after pronto.
REQ-030 All requesting: req=4'b1111 held, ptr=0 -> grants in order 0,1,2,3,0, with gnt=0 for one cycle between grants.
REQ-031 Withdrawal: req[1] dropped two cycles into CALCULA -> ack[1] still pulses and y_out holds requester 1's result.
REQ-032 Timeout (macro defined, TIMEOUT_CICLOS=15): pronto never rises -> erro pulses 16 cycles after the grant, no ack, rst_unid=1 for one cycle, next grant goes to ptr+1.
REQ-033 Reset mid-CALCULA: rst=0 -> all outputs at reset values and rst_unid=1; after release, a new req=4'b0001 is granted to requester 0.
